// File: rtl/tx_arb_pkg.sv
// tx_arb_pkg: shared types and constants for the UART transmit arbiter.
// Holds the FSM encoding, the byte width and a wrap-around index helper.
package tx_arb_pkg;

  localparam int UART_DW = 8;

  typedef enum logic [1:0] {
    ARB_IDLE = 2'd0,
    ARB_SEND = 2'd1,
    ARB_WAIT = 2'd2
  } arb_state_t;

  function automatic int wrap_inc(input int i, input int n);
    return (i + 1 >= n) ? 0 : i + 1;
  endfunction

endpackage

// File: rtl/tx_rr_pick.sv
// tx_rr_pick: combinational rotate-priority encoder.
// Ports: req (requests), ptr (start index) -> gnt_valid, gnt_idx.
module tx_rr_pick #(
  parameter  int NREQ = 4,
  localparam int IW   = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic            gnt_valid,
  output logic [IW-1:0]   gnt_idx
);

  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]   rot;
  logic [IW-1:0]     off;
  logic [IW:0]       sum;
  logic [IW:0]       wrp;

  // rot[k] is the request of index ptr+k (mod NREQ)
  assign dbl = {req, req};
  assign rot = dbl[ptr +: NREQ];

  always_comb begin
    off = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (rot[k]) off = IW'(k);
    end
  end

  assign sum = {1'b0, ptr} + {1'b0, off};
  assign wrp = (sum >= (IW+1)'(NREQ)) ? sum - (IW+1)'(NREQ) : sum;

  assign gnt_valid = |req;
  assign gnt_idx   = wrp[IW-1:0];

endmodule

// File: rtl/tx_arb.sv
// tx_arb: round-robin scheduler sharing one UART tx core among NREQ clients.
// Ports: req/req_data/ack (clients), tx_din/tx_din_rdy/tx_rdy (tx core), busy/grant_id/tmo.
module tx_arb
  import tx_arb_pkg::*;
#(
  parameter  int NREQ    = 4,
  parameter  int TMO_CYC = 65535,
  localparam int IW      = $clog2(NREQ),
  localparam int CW      = $clog2(TMO_CYC + 1)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [NREQ-1:0]         req,
  input  logic [UART_DW*NREQ-1:0] req_data,
  output logic [NREQ-1:0]         ack,
  output logic [UART_DW-1:0]      tx_din,
  output logic                    tx_din_rdy,
  input  logic                    tx_rdy,
  output logic                    busy,
  output logic [IW-1:0]           grant_id,
  output logic                    tmo
);

  arb_state_t    state;
  logic [IW-1:0] ptr;
  logic [CW-1:0] cnt;
  logic          gnt_valid;
  logic [IW-1:0] gnt_idx;

  tx_rr_pick #(.NREQ(NREQ)) u_pick (
    .req       (req),
    .ptr       (ptr),
    .gnt_valid (gnt_valid),
    .gnt_idx   (gnt_idx)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= ARB_IDLE;
      ptr        <= '0;
      cnt        <= '0;
      ack        <= '0;
      tx_din     <= '0;
      tx_din_rdy <= 1'b0;
      busy       <= 1'b0;
      grant_id   <= '0;
      tmo        <= 1'b0;
    end else begin
      ack <= '0;
      tmo <= 1'b0;
      unique case (state)
        ARB_IDLE: begin
          if (tx_rdy && gnt_valid) begin
            tx_din     <= req_data[gnt_idx*UART_DW +: UART_DW];
            grant_id   <= gnt_idx;
            ack        <= NREQ'(1) << gnt_idx;
            tx_din_rdy <= 1'b1;
            busy       <= 1'b1;
            cnt        <= '0;
            ptr        <= IW'(wrap_inc(int'(gnt_idx), NREQ));
            state      <= ARB_SEND;
          end
        end
        ARB_SEND: begin
          if (!tx_rdy) begin
            tx_din_rdy <= 1'b0;
            state      <= ARB_WAIT;
          end else if (cnt == CW'(TMO_CYC - 1)) begin
            // core never took the byte; drop it, it was already acked
            tx_din_rdy <= 1'b0;
            tmo        <= 1'b1;
            busy       <= 1'b0;
            state      <= ARB_IDLE;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        ARB_WAIT: begin
          if (tx_rdy) begin
            busy  <= 1'b0;
            state <= ARB_IDLE;
          end
        end
        default: state <= ARB_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_tx_arb.sv
// tb_tx_arb: directed bench for tx_arb with a simple tx core model.
// Checks reset, single grant, rotation, fairness, timeout, mid-frame reset.
module tb_tx_arb;

  localparam int NREQ = 4;
  localparam int TMO  = 8;

  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  req;
  logic [31:0] req_data;
  logic [3:0]  ack;
  logic [7:0]  tx_din;
  logic        tx_din_rdy;
  logic        tx_rdy;
  logic        busy;
  logic [1:0]  grant_id;
  logic        tmo;

  logic model_rdy;
  logic force_low;
  logic tx_en;
  int   frame_len = 20;
  int   frames;
  int   checks   = 0;
  int   failures = 0;

  tx_arb #(.NREQ(NREQ), .TMO_CYC(TMO)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .req_data   (req_data),
    .ack        (ack),
    .tx_din     (tx_din),
    .tx_din_rdy (tx_din_rdy),
    .tx_rdy     (tx_rdy),
    .busy       (busy),
    .grant_id   (grant_id),
    .tmo        (tmo)
  );

  always #5 clk = ~clk;

  assign tx_rdy = model_rdy && !force_low;

  // tx core: takes a load seen at a falling edge, busy for frame_len cycles
  initial begin
    model_rdy = 1'b1;
    frames    = 0;
    forever begin
      @(negedge clk);
      if (tx_en && tx_din_rdy && tx_rdy) begin
        model_rdy = 1'b0;
        frames++;
        repeat (frame_len) @(negedge clk);
        model_rdy = 1'b1;
      end
    end
  end

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_ack(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (ack == 4'b0 && n < 400);
    check(tag, 32'(ack != 4'b0), 32'd1);
  endtask

  task automatic wait_idle(input string tag);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (busy && n < 400);
    check(tag, 32'(busy), 32'd0);
  endtask

  task automatic check_zero(input string tag);
    check({tag, "_ack"}, 32'(ack), 32'd0);
    check({tag, "_din"}, 32'(tx_din), 32'd0);
    check({tag, "_rdy"}, 32'(tx_din_rdy), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_gid"}, 32'(grant_id), 32'd0);
    check({tag, "_tmo"}, 32'(tmo), 32'd0);
  endtask

  int n;
  int f0;
  int hi;
  int fexp[4] = '{3, 0, 3, 0};

  initial begin
    rst       = 1'b1;
    req       = 4'b0;
    req_data  = 32'h0;
    force_low = 1'b0;
    tx_en     = 1'b1;
    repeat (2) @(negedge clk);
    check_zero("rst");
    rst = 1'b0;

    // single request
    @(negedge clk);
    req = 4'b0010;
    req_data[15:8] = 8'hA5;
    @(negedge clk);
    check("s_ack", 32'(ack), 32'h2);
    check("s_din", 32'(tx_din), 32'hA5);
    check("s_rdy", 32'(tx_din_rdy), 32'd1);
    check("s_gid", 32'(grant_id), 32'd1);
    check("s_busy", 32'(busy), 32'd1);
    req = 4'b0;
    @(negedge clk);
    check("s_ack0", 32'(ack), 32'd0);
    check("s_rdy0", 32'(tx_din_rdy), 32'd0);
    check("s_busy1", 32'(busy), 32'd1);
    wait_idle("s_idle");

    // tx_rdy low in IDLE blocks the grant (ptr=2, winner 3)
    force_low = 1'b1;
    req = 4'b1000;
    req_data[31:24] = 8'h3C;
    repeat (3) begin
      @(negedge clk);
      check("lo_ack", 32'(ack), 32'd0);
      check("lo_rdy", 32'(tx_din_rdy), 32'd0);
    end
    force_low = 1'b0;
    @(negedge clk);
    check("lo_gack", 32'(ack), 32'h8);
    check("lo_gid", 32'(grant_id), 32'd3);
    check("lo_din", 32'(tx_din), 32'h3C);
    req = 4'b0;
    wait_idle("lo_idle");

    // all four requesting, ptr=0
    req_data = 32'h13121110;
    req = 4'hF;
    f0 = frames;
    n = 0;
    for (int c = 0; c < 2000 && n < 16; c++) begin
      @(negedge clk);
      if (ack != 4'b0) begin
        check("rr_gid", 32'(grant_id), 32'(n % 4));
        check("rr_ack", 32'(ack), 32'(1 << (n % 4)));
        check("rr_din", 32'(tx_din), 32'(8'h10 + n % 4));
        n++;
        if (n == 16) req = 4'b0;
      end
    end
    check("rr_cnt", 32'(n), 32'd16);
    wait_idle("rr_idle");
    check("rr_frames", 32'(frames - f0), 32'd16);

    // fairness: bring ptr to 1, then hold 4'b1001
    req_data = 32'h23000020;
    req = 4'b0001;
    wait_ack("f_w0");
    check("f_gid0", 32'(grant_id), 32'd0);
    req = 4'b0;
    wait_idle("f_idle0");
    req = 4'b1001;
    n = 0;
    for (int c = 0; c < 400 && n < 4; c++) begin
      @(negedge clk);
      if (ack != 4'b0) begin
        check("f_gid", 32'(grant_id), 32'(fexp[n]));
        check("f_din", 32'(tx_din), 32'(fexp[n] == 3 ? 8'h23 : 8'h20));
        n++;
        if (n == 4) req = 4'b0;
      end
    end
    check("f_cnt", 32'(n), 32'd4);
    wait_idle("f_idle");

    // timeout: ptr=1, core never responds to the first load
    req_data = 32'h00323100;
    tx_en = 1'b0;
    req = 4'b0110;
    wait_ack("t_w");
    check("t_gid", 32'(grant_id), 32'd1);
    req = 4'b0100;
    hi = 1;
    for (int c = 0; c < 50; c++) begin
      @(negedge clk);
      if (!tx_din_rdy) break;
      hi++;
    end
    check("t_hi", 32'(hi), 32'd8);
    check("t_tmo", 32'(tmo), 32'd1);
    check("t_busy", 32'(busy), 32'd0);
    tx_en = 1'b1;
    @(negedge clk);
    check("t_tmo0", 32'(tmo), 32'd0);
    check("t_ack2", 32'(ack), 32'h4);
    check("t_gid2", 32'(grant_id), 32'd2);
    check("t_din2", 32'(tx_din), 32'h32);
    req = 4'b0;
    wait_idle("t_idle");

    // reset in WAIT_DONE (ptr=3 -> winner 0)
    req_data = 32'h00550044;
    req = 4'b0001;
    wait_ack("r_w");
    check("r_gid", 32'(grant_id), 32'd0);
    req = 4'b0;
    @(negedge clk);
    check("r_wrdy", 32'(tx_din_rdy), 32'd0);
    check("r_wbusy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    check_zero("r_rst");
    rst = 1'b0;
    req = 4'b0101;
    wait_ack("r_w0");
    check("r_ptr0", 32'(grant_id), 32'd0);
    req = 4'b0100;
    wait_ack("r_w2");
    check("r_gid2", 32'(grant_id), 32'd2);
    check("r_din2", 32'(tx_din), 32'h55);
    req = 4'b0;
    wait_idle("r_idle");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
